// File: rtl/seqgen_pkg.sv
// Shared types and sizing helpers for the serial pattern generator.
package seqgen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic int idx_w(input int pat_w);
        return $clog2(pat_w);
    endfunction

    // Zero or over-long lengths fall back to the full pattern width.
    function automatic int sat_len(input int len, input int pat_w);
        return (len == 0 || len > pat_w) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seqgen_shreg.sv
// Parallel-load, MSB-out shift register; clear beats load beats shift, zeros shift in.
module seqgen_shreg #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_dat,
    output logic             o_msb
);

    logic [PAT_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_dat;
        end else if (i_shift) begin
            r_q <= {r_q[PAT_W-2:0], 1'b0};
        end
    end

    assign o_msb = r_q[PAT_W-1];

endmodule

// File: rtl/sequence_pattern_generator.sv
// Serialises a captured pattern MSB-first, first bit the cycle after accept, one bit/clk, optional repeats.
// load_ready only in IDLE (not while abort); SEQGEN_GAP_EN inserts GAP_BITS zeros between repetitions.
module sequence_pattern_generator
    import seqgen_pkg::*;
#(
    parameter int PAT_W    = 8,
    parameter int CNT_W    = 4,
    parameter int GAP_BITS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [$clog2(PAT_W+1)-1:0] len,
    input  logic [CNT_W-1:0]           repeat_cnt,
    input  logic                       abort,
    output logic                       dout,
    output logic                       dout_valid,
    output logic                       frame_start,
    output logic                       done,
    output logic                       busy
);

    localparam int LEN_W = len_w(PAT_W);
    localparam int IDX_W = idx_w(PAT_W);

    if (PAT_W < 2 || GAP_BITS < 1) begin : g_bad_params
        $error("sequence_pattern_generator: PAT_W must be >= 2 and GAP_BITS >= 1");
    end

    state_t             r_state, w_state_nxt;
    logic [PAT_W-1:0]   r_pat;
    logic [IDX_W-1:0]   r_len_m1;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_rep, w_rep_nxt;
    logic               r_vld, w_vld_nxt;
    logic               r_fs, w_fs_nxt;
    logic               r_done, w_done_nxt;
`ifdef SEQGEN_GAP_EN
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
`endif

    logic               w_accept;
    logic [LEN_W-1:0]   w_len_sat;
    logic [LEN_W-1:0]   w_shamt;
    logic [IDX_W-1:0]   w_len_m1;
    logic [PAT_W-1:0]   w_pat_algn;
    logic               w_sr_clr, w_sr_load, w_sr_shift, w_sr_msb;
    logic [PAT_W-1:0]   w_sr_dat;

    assign load_ready = (r_state == IDLE) && rst && !abort;
    assign w_accept   = load_valid && load_ready;

    // Left-align so the first bit to send sits at the MSB and unused bits fall off the top.
    assign w_len_sat  = LEN_W'(sat_len(int'(len), PAT_W));
    assign w_shamt    = LEN_W'(PAT_W) - w_len_sat;
    assign w_len_m1   = IDX_W'(w_len_sat - LEN_W'(1));
    assign w_pat_algn = pattern << w_shamt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_idx == '0) begin
                    if (r_rep == '0) w_state_nxt = IDLE;
`ifdef SEQGEN_GAP_EN
                    else w_state_nxt = GAP;
`endif
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                if (abort)              w_state_nxt = IDLE;
                else if (r_gap == '0)   w_state_nxt = SHIFT;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered: this computes what the next cycle shows.
    always_comb begin
        w_sr_clr   = 1'b0;
        w_sr_load  = 1'b0;
        w_sr_shift = 1'b0;
        w_sr_dat   = r_pat;
        w_idx_nxt  = r_idx;
        w_rep_nxt  = r_rep;
        w_vld_nxt  = 1'b0;
        w_fs_nxt   = 1'b0;
        w_done_nxt = 1'b0;
`ifdef SEQGEN_GAP_EN
        w_gap_nxt  = r_gap;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_sr_load  = 1'b1;
                    w_sr_dat   = w_pat_algn;
                    w_idx_nxt  = w_len_m1;
                    w_rep_nxt  = repeat_cnt;
                    w_vld_nxt  = 1'b1;
                    w_fs_nxt   = 1'b1;
                    w_done_nxt = (w_len_m1 == '0) && (repeat_cnt == '0);
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_sr_clr = 1'b1;
                end else begin
                    w_sr_shift = 1'b1;
                    if (r_idx != '0) begin
                        w_idx_nxt  = r_idx - IDX_W'(1);
                        w_vld_nxt  = 1'b1;
                        w_done_nxt = (r_idx == IDX_W'(1)) && (r_rep == '0);
                    end else if (r_rep != '0) begin
                        w_rep_nxt = r_rep - CNT_W'(1);
                        w_vld_nxt = 1'b1;
`ifdef SEQGEN_GAP_EN
                        w_gap_nxt = GAP_W'(GAP_BITS - 1);
`else
                        w_sr_load  = 1'b1;
                        w_idx_nxt  = r_len_m1;
                        w_fs_nxt   = 1'b1;
                        w_done_nxt = (r_len_m1 == '0) && (r_rep == CNT_W'(1));
`endif
                    end
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                if (abort) begin
                    w_sr_clr = 1'b1;
                end else if (r_gap != '0) begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                    w_vld_nxt = 1'b1;
                end else begin
                    w_sr_load  = 1'b1;
                    w_idx_nxt  = r_len_m1;
                    w_vld_nxt  = 1'b1;
                    w_fs_nxt   = 1'b1;
                    w_done_nxt = (r_len_m1 == '0) && (r_rep == '0);
                end
            end
`endif
            default: w_sr_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat    <= '0;
            r_len_m1 <= '0;
            r_idx    <= '0;
            r_rep    <= '0;
            r_vld    <= 1'b0;
            r_fs     <= 1'b0;
            r_done   <= 1'b0;
`ifdef SEQGEN_GAP_EN
            r_gap    <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_pat    <= w_pat_algn;
                r_len_m1 <= w_len_m1;
            end
            r_idx  <= w_idx_nxt;
            r_rep  <= w_rep_nxt;
            r_vld  <= w_vld_nxt;
            r_fs   <= w_fs_nxt;
            r_done <= w_done_nxt;
`ifdef SEQGEN_GAP_EN
            r_gap  <= w_gap_nxt;
`endif
        end
    end

    seqgen_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst),
        .i_clr   (w_sr_clr),
        .i_load  (w_sr_load),
        .i_shift (w_sr_shift),
        .i_dat   (w_sr_dat),
        .o_msb   (w_sr_msb)
    );

    assign dout        = w_sr_msb;
    assign dout_valid  = r_vld;
    assign frame_start = r_fs;
    assign done        = r_done;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Scoreboard bench for sequence_pattern_generator (PAT_W=8, CNT_W=4, GAP_BITS=1).
module tb_sequence_pattern_generator;

    localparam int GAP_BITS_TB = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_cnt;
    logic       abort;
    logic       dout, dout_valid, frame_start, done, busy;

    typedef struct {
        logic d;
        logic fs;
        logic dn;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   vcount = 0;
    int   fs_cnt = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    sequence_pattern_generator #(
        .PAT_W    (8),
        .CNT_W    (4),
        .GAP_BITS (GAP_BITS_TB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .pattern     (pattern),
        .len         (len),
        .repeat_cnt  (repeat_cnt),
        .abort       (abort),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .done        (done),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] p, input int l, input int r);
        int eff_len;
        eff_len = (l == 0 || l > 8) ? 8 : l;
        for (int k = 0; k <= r; k++) begin
            for (int i = eff_len - 1; i >= 0; i--) begin
                exp_t e;
                e.d  = p[i];
                e.fs = (i == eff_len - 1);
                e.dn = (k == r) && (i == 0);
                sb.push_back(e);
            end
`ifdef SEQGEN_GAP_EN
            if (k < r) begin
                for (int g = 0; g < GAP_BITS_TB; g++) sb.push_back('{1'b0, 1'b0, 1'b0});
            end
`endif
        end
    endtask

    // Called at a negedge; returns 1ns after the accepting posedge.
    task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, output int waits);
        load_valid = 1'b1;
        pattern    = p;
        len        = l;
        repeat_cnt = r;
        waits      = 0;
        while (!load_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!load_ready) begin
            chk("send_timeout", 32'(load_ready), 1);
            load_valid = 1'b0;
        end else begin
            push_frame(p, int'(l), int'(r));
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            pattern    = 8'($urandom);
            len        = 4'($urandom);
            repeat_cnt = 4'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dout_valid) begin
            vcount++;
            if (sb.size() == 0) begin
                chk("unexpected_bit", 32'(dout_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("dout", 32'(dout), 32'(e.d));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
                chk("done", 32'(done), 32'(e.dn));
            end
        end else begin
            chk("idle_dout", 32'(dout), 0);
            chk("idle_fs", 32'(frame_start), 0);
            chk("idle_done", 32'(done), 0);
        end
        if (frame_start) fs_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, v0, f0, d0, exp_v;
        rst        = 1'b0;
        load_valid = 1'b0;
        pattern    = '0;
        len        = '0;
        repeat_cnt = '0;
        abort      = 1'b0;
        #2;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_vld", 32'(dout_valid), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy", 32'(load_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(load_ready), 1);
        abort = 1'b1;
        #1;
        chk("abort_blocks_rdy", 32'(load_ready), 0);
        abort = 1'b0;
        @(negedge clk);

        // Single 8-bit frame, latency and turnaround
        send(8'hB7, 4'd8, 4'd0, w);
        @(negedge clk);
        chk("t1_c1_vld", 32'(dout_valid), 1);
        chk("t1_c1_fs", 32'(frame_start), 1);
        chk("t1_c1_busy", 32'(busy), 1);
        repeat (7) @(negedge clk);
        chk("t1_c8_done", 32'(done), 1);
        chk("t1_c8_rdy", 32'(load_ready), 0);
        @(negedge clk);
        chk("t1_c9_rdy", 32'(load_ready), 1);
        chk("t1_c9_vld", 32'(dout_valid), 0);
        chk("t1_c9_busy", 32'(busy), 0);

        // Repeated short pattern; upper pattern bits must be ignored
        v0 = vcount;
        f0 = fs_cnt;
        send(8'hF7, 4'd3, 4'd2, w);
        wait_idle();
`ifdef SEQGEN_GAP_EN
        exp_v = 11;
`else
        exp_v = 9;
`endif
        chk("t2_valid_cycles", 32'(vcount - v0), 32'(exp_v));
        chk("t2_frame_starts", 32'(fs_cnt - f0), 3);

        // Abort during bit 4
        d0 = done_cnt;
        send(8'hB7, 4'd8, 4'd0, w);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("t3_vld", 32'(dout_valid), 0);
        chk("t3_dout", 32'(dout), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_rdy", 32'(load_ready), 1);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("t3_no_done", 32'(done_cnt - d0), 0);

        // Asynchronous reset mid-frame, then a normal load
        send(8'hB7, 4'd8, 4'd0, w);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_dout", 32'(dout), 0);
        chk("t4_vld", 32'(dout_valid), 0);
        chk("t4_fs", 32'(frame_start), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_rdy", 32'(load_ready), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(8'h5A, 4'd8, 4'd1, w);
        wait_idle();

        // len saturation: 0 and 9 both mean 8
        v0 = vcount;
        send(8'h81, 4'd0, 4'd0, w);
        wait_idle();
        chk("t5_len0_cycles", 32'(vcount - v0), 8);
        v0 = vcount;
        send(8'h81, 4'd9, 4'd0, w);
        wait_idle();
        chk("t5_len9_cycles", 32'(vcount - v0), 8);

        // Load held while busy is accepted only on the first IDLE cycle
        send(8'hC3, 4'd8, 4'd0, w);
        repeat (2) @(negedge clk);
        chk("t6_rdy_busy", 32'(load_ready), 0);
        send(8'h96, 4'd4, 4'd1, w);
        chk("t6_wait_cycles", 32'(w), 7);
        wait_idle();

        // Maximum repeat count must not wrap
        v0 = vcount;
        d0 = done_cnt;
        send(8'h02, 4'd2, 4'd15, w);
        wait_idle();
`ifdef SEQGEN_GAP_EN
        exp_v = 47;
`else
        exp_v = 32;
`endif
        chk("t7_valid_cycles", 32'(vcount - v0), 32'(exp_v));
        chk("t7_done_count", 32'(done_cnt - d0), 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
